// File: rtl/code_sequencer4_if.sv
`default_nettype none
// ============================================================================
// Module   : code_sequencer4_if
// Purpose  : Bundles the control inputs and registered outputs of
//            code_sequencer4 into a single interface.
// Ports    : none (signal bundle only)
//   start, stop, dir, mode          sweep control (master -> slave)
//   start_code, end_code            sweep range   (master -> slave)
//   dwell_cycles [DWELL_W]          extra hold cycles per code
//   pause                           freeze sweep (only with SEQ_PAUSE_EN)
//   data_out [4], valid, busy, done sequencer outputs (slave -> master)
// Macro    : SEQ_PAUSE_EN adds the pause signal.
// Revision : 1.0 - initial release
// ============================================================================
interface code_sequencer4_if #(
  parameter int DWELL_W = 8
) ();
  logic               start;
  logic               stop;
  logic               dir;
  logic               mode;
  logic [3:0]         start_code;
  logic [3:0]         end_code;
  logic [DWELL_W-1:0] dwell_cycles;
`ifdef SEQ_PAUSE_EN
  logic               pause;
`endif
  logic [3:0]         data_out;
  logic               valid;
  logic               busy;
  logic               done;

  // Stimulus side: drives control, observes the sequencer outputs.
  modport master (
`ifdef SEQ_PAUSE_EN
    output pause,
`endif
    output start, stop, dir, mode, start_code, end_code, dwell_cycles,
    input  data_out, valid, busy, done
  );

  // Sequencer side.
  modport slave (
`ifdef SEQ_PAUSE_EN
    input  pause,
`endif
    input  start, stop, dir, mode, start_code, end_code, dwell_cycles,
    output data_out, valid, busy, done
  );
endinterface : code_sequencer4_if
`default_nettype wire

// File: rtl/code_sequencer4.sv
`default_nettype none
// ============================================================================
// Module   : code_sequencer4
// Purpose  : Steps a 4-bit code through a programmed range, holding each
//            code for dwell_cycles+1 clocks, to drive decoder4to16 data_in.
//            Up/down direction, single or continuous sweep, start/stop.
// Ports    :
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of code_sequencer4_if:
//            start/stop/dir/mode/start_code/end_code/dwell_cycles in,
//            data_out/valid/busy/done out (all registered)
// Macro    : SEQ_PAUSE_EN - adds bus.pause, which freezes the sweep in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module code_sequencer4 #(
  parameter int DWELL_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  code_sequencer4_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Registered outputs and their next values
  logic [3:0]         r_data;
  logic [3:0]         w_data_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;

  // Dwell counter
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;

  // Sweep configuration captured at start
  logic [3:0]         r_start_code;
  logic [3:0]         r_end_code;
  logic               r_dir;
  logic               r_mode;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_capture;
  logic               w_pause;
  logic [3:0]         w_step;

`ifdef SEQ_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  // stop has priority over start, so a simultaneous request starts nothing.
  assign w_capture = (r_state == S_IDLE) && bus.start && !bus.stop;

  // 4-bit arithmetic gives the modulo-16 wrap in both directions.
  assign w_step = r_dir ? (r_data - 4'd1) : (r_data + 4'd1);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= 4'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Configuration is only sampled on an accepted start; later input changes
  // do not disturb a sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_code <= 4'd0;
      r_end_code   <= 4'd0;
      r_dir        <= 1'b0;
      r_mode       <= 1'b0;
      r_dwell      <= '0;
    end else if (w_capture) begin
      r_start_code <= bus.start_code;
      r_end_code   <= bus.end_code;
      r_dir        <= bus.dir;
      r_mode       <= bus.mode;
      r_dwell      <= bus.dwell_cycles;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (w_capture) begin
          // First code comes straight from the port: the latched copy is
          // being written on this same edge.
          w_state_nxt = S_RUN;
          w_data_nxt  = bus.start_code;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (w_pause) begin
          // Hold code and counter so the remaining dwell survives the pause.
          w_state_nxt = S_RUN;
        end else if (r_cnt < r_dwell) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
          if (r_data == r_end_code) begin
            if (r_mode) begin
              w_data_nxt = r_start_code;
            end else begin
              // Last code of a single sweep: data_out keeps the end code.
              w_state_nxt = S_DONE;
              w_valid_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_data_nxt = w_step;
          end
        end
      end

      S_DONE: begin
        // done is high for this one cycle only; stop also lands in IDLE.
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule : code_sequencer4
`default_nettype wire

// File: tb/tb_code_sequencer4.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_sequencer4
// Purpose  : Self-checking bench for code_sequencer4. Expected per-cycle
//            outputs are queued when a sweep is launched and compared on
//            each falling edge.
// Macro    : SEQ_PAUSE_EN - also exercises the pause input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_sequencer4;

  localparam int c_dwell_w = 8;

  logic clk;
  logic rst_n;

  code_sequencer4_if #(.DWELL_W(c_dwell_w)) bus ();

  code_sequencer4 #(.DWELL_W(c_dwell_w)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input logic [3:0] d, input logic v, input logic b, input logic dn);
    exp_t e;
    e.data = d; e.valid = v; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  // Pop one expectation and compare against the current outputs.
  task automatic compare_now(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"},  {28'd0, bus.data_out}, {28'd0, e.data});
      chk({tag, "_valid"}, {31'd0, bus.valid},    {31'd0, e.valid});
      chk({tag, "_busy"},  {31'd0, bus.busy},     {31'd0, e.busy});
      chk({tag, "_done"},  {31'd0, bus.done},     {31'd0, e.done});
    end
  endtask

  // Compare n cycles, advancing one falling edge after each.
  task automatic pump(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      compare_now(tag);
      @(negedge clk);
    end
  endtask

  // Program the range and pulse start for one cycle; returns on the falling
  // edge where the first code should be visible.
  task automatic start_sweep(input logic [3:0] sc, input logic [3:0] ec,
                             input logic d, input logic m,
                             input logic [c_dwell_w-1:0] dw);
    bus.start_code   = sc;
    bus.end_code     = ec;
    bus.dir          = d;
    bus.mode         = m;
    bus.dwell_cycles = dw;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.dir          = 1'b0;
    bus.mode         = 1'b0;
    bus.start_code   = 4'd0;
    bus.end_code     = 4'd0;
    bus.dwell_cycles = '0;
`ifdef SEQ_PAUSE_EN
    bus.pause        = 1'b0;
`endif

    // Reset state
    #2;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    compare_now("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Down sweep 15 -> 0, no dwell
    start_sweep(4'd15, 4'd0, 1'b1, 1'b0, 8'd0);
    for (int c = 15; c >= 0; c--) push(4'(c), 1'b1, 1'b1, 1'b0);
    push(4'd0, 1'b0, 1'b0, 1'b1);
    push(4'd0, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b0, 1'b0, 1'b0);
    pump("down16", 19);

    // Up 3..5, dwell 2; start re-asserted with new inputs mid-sweep
    start_sweep(4'd3, 4'd5, 1'b0, 1'b0, 8'd2);
    for (int c = 3; c <= 5; c++) repeat (3) push(4'(c), 1'b1, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b0, 1'b1);
    push(4'd5, 1'b0, 1'b0, 1'b0);
    pump("dwell2", 4);
    bus.start        = 1'b1;
    bus.start_code   = 4'd0;
    bus.dwell_cycles = 8'd7;
    pump("dwell2_restart", 3);
    bus.start        = 1'b0;
    pump("dwell2_tail", 4);

    // Continuous wrap 14,15,0,1 and stop on code 0
    start_sweep(4'd14, 4'd1, 1'b0, 1'b1, 8'd0);
    repeat (2) begin
      push(4'd14, 1'b1, 1'b1, 1'b0);
      push(4'd15, 1'b1, 1'b1, 1'b0);
      push(4'd0,  1'b1, 1'b1, 1'b0);
      push(4'd1,  1'b1, 1'b1, 1'b0);
    end
    push(4'd14, 1'b1, 1'b1, 1'b0);
    push(4'd15, 1'b1, 1'b1, 1'b0);
    pump("wrap", 10);
    bus.stop = 1'b1;
    push(4'd0, 1'b1, 1'b1, 1'b0);
    pump("wrap_stop", 1);
    bus.stop = 1'b0;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b0, 1'b0, 1'b0);
    pump("after_stop", 2);

    // start and stop together in IDLE: nothing begins
    bus.start_code = 4'd7;
    bus.start      = 1'b1;
    bus.stop       = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    repeat (3) push(4'd0, 1'b0, 1'b0, 1'b0);
    pump("start_stop", 3);

    // Asynchronous reset mid-sweep at code 9
    start_sweep(4'd5, 4'd12, 1'b0, 1'b0, 8'd0);
    for (int c = 5; c <= 8; c++) push(4'(c), 1'b1, 1'b1, 1'b0);
    pump("pre_reset", 4);
    push(4'd9, 1'b1, 1'b1, 1'b0);
    compare_now("at_nine");
    #2;
    rst_n = 1'b0;
    #1;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    compare_now("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) push(4'd0, 1'b0, 1'b0, 1'b0);
    pump("post_reset", 3);

    // One-code sweep
    start_sweep(4'd2, 4'd2, 1'b0, 1'b0, 8'd0);
    push(4'd2, 1'b1, 1'b1, 1'b0);
    push(4'd2, 1'b0, 1'b0, 1'b1);
    push(4'd2, 1'b0, 1'b0, 1'b0);
    pump("one_code", 3);

`ifdef SEQ_PAUSE_EN
    // Pause for 5 cycles on the second cycle of code 7 (dwell 3)
    start_sweep(4'd6, 4'd9, 1'b0, 1'b0, 8'd3);
    repeat (4) push(4'd6, 1'b1, 1'b1, 1'b0);
    repeat (9) push(4'd7, 1'b1, 1'b1, 1'b0);
    repeat (4) push(4'd8, 1'b1, 1'b1, 1'b0);
    repeat (4) push(4'd9, 1'b1, 1'b1, 1'b0);
    push(4'd9, 1'b0, 1'b0, 1'b1);
    push(4'd9, 1'b0, 1'b0, 1'b0);
    pump("pause_pre", 5);
    bus.pause = 1'b1;
    pump("pause_hold", 5);
    bus.pause = 1'b0;
    pump("pause_post", 13);
`endif

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_code_sequencer4
`default_nettype wire
